sram_stream_reader: RTL and testbench
=====================================

SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning SRAM word width.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning SRAM address width (4096 words).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, captured with start.
REQ-007 SHALL have port length  input  ADDR_W+1  word count 0..4096, captured with start.
REQ-008 SHALL have port abort  input  1  synchronous burst cancel.
REQ-009 SHALL have port sram_addr  output  ADDR_W  registered address to the M10K SRAM.
REQ-010 SHALL have port sram_we  output  1  SRAM write enable, constant 0.
REQ-011 SHALL have port sram_d  output  DATA_W  SRAM write data, constant 0.
REQ-012 SHALL have port sram_q  input  DATA_W  SRAM read data, valid one cycle after sram_addr is sampled.
REQ-013 SHALL have port out_data  output  DATA_W  stream data to the downstream MAC.
REQ-014 SHALL have port out_valid  output  1  out_data valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-016 SHALL have port out_last  output  1  marks the final beat of a burst.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse on burst completion.

Function
REQ-019 SHALL implement states IDLE, RUN and DRAIN.
REQ-020 IDLE with start=1 and length>0 SHALL load sram_addr=base_addr and remaining=length, then move to RUN.
REQ-021 IDLE with start=1 and length=0 SHALL pulse done on the next cycle, emit no beats and stay in IDLE.
REQ-022 In RUN, a read SHALL issue on each edge where remaining>0 and credit allows; each issue increments sram_addr (mod 2^ADDR_W, 4095 wraps to 0), decrements remaining and marks one read in flight.
REQ-023 sram_addr SHALL hold its value while no read issues (stall).
REQ-024 An in-flight read SHALL be captured from sram_q into a 2-entry output FIFO on the edge after it issues.
REQ-025 Credit rule: a read SHALL issue only when fifo_count + in_flight - pop < 2, where pop = out_valid & out_ready on that edge.
REQ-026 With out_ready held high the block SHALL sustain one beat per cycle.
REQ-027 out_valid SHALL be high whenever the FIFO is non-empty; out_data SHALL be the FIFO head; FIFO order SHALL equal address order.
REQ-028 out_valid/out_data SHALL stay stable until the beat is accepted.
REQ-029 First-beat latency: start sampled at edge E0 -> first issue at E1 -> FIFO capture at E2 -> out_valid high after E2.
REQ-030 out_last SHALL be high exactly on the beat carrying the length-th word.
REQ-031 RUN SHALL move to DRAIN when the last read issues; DRAIN SHALL move to IDLE on the edge where the out_last beat is accepted; done SHALL pulse in the following cycle.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 abort SHALL, on the next edge and from any state, flush the FIFO, clear the in-flight count and remaining, deassert out_valid and return to IDLE, with no done pulse.
REQ-034 If abort coincides with an accepted out_last beat, that beat SHALL count as consumed, but abort takes precedence and done SHALL NOT pulse.
REQ-035 A read in flight at abort SHALL be discarded.

Reset
REQ-036 rst_n low SHALL immediately force IDLE, sram_addr=0, FIFO empty, in_flight=0, remaining=0, out_valid=0, out_last=0, out_data=0, busy=0 and done=0.
REQ-037 Reset asserted mid-burst SHALL discard all pending data; the first start after deassertion SHALL behave as from power-up.

Verification
REQ-038 SRAM preloaded mem[i]=i, base=10, length=4, out_ready=1 -> beats 10,11,12,13 on consecutive cycles, first after E2; out_last on 13; done one cycle later.
REQ-039 base=4094, length=4 -> beats from addresses 4094,4095,0,1; sram_addr wraps to 0 without error.
REQ-040 length=8 with out_ready toggling 1,0,0,1 pseudo-randomly -> all 8 words in order, none duplicated or lost; out_data stable while stalled; in_flight+fifo_count never exceeds 2.
REQ-041 length=0 -> done pulses once, out_valid never asserts; start during RUN -> ignored, original burst completes unchanged.
REQ-042 abort on the 3rd beat of a length-6 burst -> out_valid low next cycle, no done, busy=0; a new burst then returns correct data.
REQ-043 rst_n pulsed low mid-burst -> all outputs zero asynchronously; a following burst with base=0, length=2 yields 0,1.

Source files
------------

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: streams a burst of consecutive SRAM words onto a valid/ready port.
// Latency: start sampled at E0, first read issues at E1, first beat valid after E2; 1 beat/cycle with out_ready high.
// Backpressure: reads are credit-limited (FIFO + in-flight <= 2); a stalled beat holds out_data/out_last stable.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start/base_addr/length- burst request, captured only while idle (length 0..2^ADDR_W)
//   abort                 - synchronous cancel, flushes everything, no done pulse
//   sram_addr/we/d/q      - read-only port to a 1-cycle-latency synchronous SRAM
//   out_data/valid/ready/last - output stream
//   busy, done            - status: not idle / one-cycle burst-complete pulse

// Small generic synchronous FIFO with flush. The caller never pushes when
// full nor pops when empty.
module sram_stream_reader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_dat,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module sram_stream_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   remaining;
    logic              in_flight;
    logic              in_flight_last;   // the read in flight carries the final word
    logic [1:0]        fifo_count;
    logic [DATA_W:0]   fifo_head;        // {last, data}
    logic              pop;
    logic              issue;
    logic              credit_ok;
    logic              accept_last;
    logic              last_issue;

    assign sram_we = 1'b0;
    assign sram_d  = '0;

    assign out_valid   = (fifo_count != 2'd0);
    assign out_data    = out_valid ? fifo_head[DATA_W-1:0] : '0;
    assign out_last    = out_valid & fifo_head[DATA_W];
    assign busy        = (state != IDLE);
    assign pop         = out_valid & out_ready;
    assign accept_last = pop & out_last;

    // A new read may issue only if, counting the beat leaving this edge,
    // the FIFO plus the read already in flight leave room for it.
    assign credit_ok  = (({1'b0, fifo_count} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop}));
    assign last_issue = issue && (remaining == (ADDR_W+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start && (length != '0)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue = (remaining != '0) && credit_ok;
                if (issue && (remaining == (ADDR_W+1)'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (accept_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // abort wins over everything, including a coinciding last-beat accept
        if (abort) begin
            state_nxt = IDLE;
            issue     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr      <= '0;
            remaining      <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                remaining      <= '0;
                in_flight      <= 1'b0;
                in_flight_last <= 1'b0;
            end else begin
                in_flight      <= issue;
                in_flight_last <= last_issue;
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (length != '0) begin
                                sram_addr <= base_addr;
                                remaining <= length;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (issue) begin
                            sram_addr <= sram_addr + 1'b1;   // wraps naturally at 2^ADDR_W
                            remaining <= remaining - 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (accept_last) begin
                            done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The SRAM returns data one edge after the address is sampled, so the
    // read issued last edge is captured now. A read in flight at abort is dropped.
    sram_stream_reader_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .push     (in_flight & ~abort),
        .push_dat ({in_flight_last, sram_q}),
        .pop      (pop & ~abort),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_sram_stream_reader.sv
module tb_sram_stream_reader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [0:4095];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int base;
        int len;
        int mode;          // 0: out_ready held high, 1: random out_ready
        int abort_beat;    // beat index accepted together with abort, -1 none
        int exp_beats;
        int exp_done;
        int exp_end_addr;  // -1: not checked
    } vec_t;

    sram_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .sram_addr (sram_addr),
        .sram_we   (sram_we),
        .sram_d    (sram_d),
        .sram_q    (sram_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // synchronous SRAM, one cycle read latency
    always @(posedge clk) sram_q <= mem[sram_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one burst and score it against the expected word sequence
    // mem[(base+i) mod 4096] with the last flag on beat len-1.
    task automatic run_burst(input int base, input int len, input int mode, input int abort_beat,
                             output int nbeats, output int ndone);
        int idx;
        int cycles;
        int post;
        int limit;
        bit ended;
        bit accept;
        bit do_abort;
        bit prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic [DATA_W-1:0] exp_dat;
        idx = 0; cycles = 0; post = 0; nbeats = 0; ndone = 0;
        limit = 4 * len + 60;
        ended = (len == 0);
        prev_stall = 1'b0;
        prev_data = '0;
        base_addr = ADDR_W'(base);
        length = (ADDR_W+1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (post < 3 && cycles < limit) begin
            if (done) ndone++;
            check("extra_beat", 32'(out_valid && (ended || idx >= len)), 0);
            if (prev_stall) check("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
            check("credit", 32'((int'(dut.in_flight) + int'(dut.fifo_count)) <= 2), 1);
            if (out_valid && !ended && idx < len) begin
                exp_dat = DATA_W'((base + idx) % 4096);
                check("beat_data", out_data, exp_dat);
                check("beat_last", out_last, 32'(idx == len - 1));
            end
            out_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            accept = out_valid && out_ready;
            do_abort = accept && (idx == abort_beat);
            abort = do_abort;
            if (cycles == 3 && busy && !ended) begin
                // must be ignored: burst already running
                start = 1'b1;
                base_addr = '0;
                length = (ADDR_W+1)'(1);
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            tick();
            abort = 1'b0;
            start = 1'b0;
            if (accept) begin
                idx++;
                nbeats++;
            end
            if (do_abort) begin
                ended = 1'b1;
                prev_stall = 1'b0;
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
            end
            if (!ended && idx == len) ended = 1'b1;
            if (ended) post++;
            cycles++;
        end
        if (post < 3) check("burst_timeout", post, 3);
    endtask

    vec_t vecs[9];

    initial begin
        int nb;
        int nd;
        int b;
        int l;
        int m;
        int ab;
        vecs[0] = '{10,   4,    0, -1, 4,    1, 14};
        vecs[1] = '{4094, 4,    0, -1, 4,    1, 2};
        vecs[2] = '{100,  8,    1, -1, 8,    1, 108};
        vecs[3] = '{0,    0,    0, -1, 0,    1, 108};
        vecs[4] = '{200,  6,    0, 2,  3,    0, -1};
        vecs[5] = '{4095, 1,    0, -1, 1,    1, 0};
        vecs[6] = '{50,   5,    0, 4,  5,    0, 55};
        vecs[7] = '{300,  16,   1, -1, 16,   1, 316};
        vecs[8] = '{7,    4096, 0, -1, 4096, 1, 7};

        for (int i = 0; i < 4096; i++) mem[i] = DATA_W'(i);

        // reset state
        rst_n = 1'b0;
        #2;
        check("rst_sram_addr", sram_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_d", sram_d, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // first-beat latency and back-to-back throughput
        base_addr = 10; length = 4; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_e0_valid", out_valid, 0);
        check("lat_e0_busy", busy, 1);
        check("lat_e0_addr", sram_addr, 10);
        tick();
        check("lat_e1_valid", out_valid, 0);
        check("lat_e1_addr", sram_addr, 11);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("seq_valid", out_valid, 1);
            check("seq_data", out_data, 10 + k);
            check("seq_last", out_last, 32'(k == 3));
            check("seq_done", done, 0);
        end
        tick();
        check("seq_done_pulse", done, 1);
        check("seq_end_valid", out_valid, 0);
        check("seq_end_busy", busy, 0);
        tick();
        check("seq_done_once", done, 0);

        // table of bursts
        for (int v = 0; v < 9; v++) begin
            run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].abort_beat, nb, nd);
            check("vec_beats", nb, vecs[v].exp_beats);
            check("vec_done", nd, vecs[v].exp_done);
            check("vec_busy", busy, 0);
            if (vecs[v].exp_end_addr >= 0) check("vec_end_addr", sram_addr, vecs[v].exp_end_addr);
        end

        // reset in the middle of a burst
        base_addr = 20; length = 8; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("mid_valid_before", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_last", out_last, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_addr", sram_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_burst(0, 2, 0, -1, nb, nd);
        check("post_rst_beats", nb, 2);
        check("post_rst_done", nd, 1);

        // randomized bursts against the address-sequence model
        for (int r = 0; r < 20; r++) begin
            b = $urandom_range(0, 4095);
            l = $urandom_range(0, 24);
            m = $urandom_range(0, 1);
            ab = (l > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, l - 1) : -1;
            run_burst(b, l, m, ab, nb, nd);
            check("rnd_beats", nb, (ab >= 0) ? ab + 1 : l);
            check("rnd_done", nd, (ab >= 0) ? 0 : 1);
            if (ab < 0 && l > 0) check("rnd_end_addr", sram_addr, (b + l) % 4096);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
